// File: rtl/stream_to_vector.sv
// Packs NUM_OUTPUTS consecutive scalar samples into one vector and presents it on
// per-lane ready/valid outputs; assembly and output buffers are independent (double-buffered).
module stream_to_vector #(
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_OUTPUTS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   s2v_ready_in,
    input  logic                   s2v_valid_in,
    input  logic                   s2v_sof_in,
    input  logic [DATA_WIDTH-1:0]  s2v_data_in,
    input  logic [NUM_OUTPUTS-1:0] s2v_ready_out,
    output logic [NUM_OUTPUTS-1:0] s2v_valid_out,
    output logic [DATA_WIDTH-1:0]  s2v_data_out [0:NUM_OUTPUTS-1],
    output logic                   s2v_frame_err
);

    localparam int CW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam logic [CW-1:0]          LAST     = CW'(NUM_OUTPUTS - 1);
    localparam logic [CW-1:0]          ONE      = CW'(1);
    localparam logic [NUM_OUTPUTS-1:0] ALL_ONES = {NUM_OUTPUTS{1'b1}};
    localparam logic [NUM_OUTPUTS-1:0] NONE     = {NUM_OUTPUTS{1'b0}};

    logic [CW-1:0]          cnt_r,  cnt_nxt_s;
    logic [NUM_OUTPUTS-1:0] pend_r, pend_nxt_s;
    logic                   err_r,  err_nxt_s;
    logic [DATA_WIDTH-1:0]  asm_r     [0:NUM_OUTPUTS-1];
    logic [DATA_WIDTH-1:0]  asm_nxt_s [0:NUM_OUTPUTS-1];
    logic [DATA_WIDTH-1:0]  out_r     [0:NUM_OUTPUTS-1];
    logic [DATA_WIDTH-1:0]  out_nxt_s [0:NUM_OUTPUTS-1];
    logic                   accept_s;
    logic                   sof_err_s;

    // Only the frame-completing sample needs a free output buffer, so ready depends on registers alone.
    assign s2v_ready_in  = (cnt_r != LAST) || (pend_r == NONE);
    assign accept_s      = s2v_valid_in && s2v_ready_in;
    assign sof_err_s     = accept_s && s2v_sof_in && (cnt_r != {CW{1'b0}});
    assign s2v_valid_out = pend_r;
    assign s2v_data_out  = out_r;
    assign s2v_frame_err = err_r;

    // Next-state: lane drains, sample assembly, frame load and sof realignment.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        asm_nxt_s  = asm_r;
        out_nxt_s  = out_r;
        pend_nxt_s = pend_r & ~s2v_ready_out;
        err_nxt_s  = 1'b0;
        if (accept_s) begin
            if (sof_err_s) begin
                asm_nxt_s[0] = s2v_data_in;
                cnt_nxt_s    = ONE;
                err_nxt_s    = 1'b1;
            end else if (cnt_r == LAST) begin
                for (int i = 0; i < NUM_OUTPUTS - 1; i++) begin
                    out_nxt_s[i] = asm_r[i];
                end
                out_nxt_s[NUM_OUTPUTS-1] = s2v_data_in;
                // A load can only coincide with an already-empty mask, so it simply overrides the drain.
                pend_nxt_s = ALL_ONES;
                cnt_nxt_s  = {CW{1'b0}};
            end else begin
                asm_nxt_s[cnt_r] = s2v_data_in;
                cnt_nxt_s        = cnt_r + ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers with synchronous reset taking priority over all traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            pend_r <= NONE;
            err_r  <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                asm_r[i] <= {DATA_WIDTH{1'b0}};
                out_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            cnt_r  <= cnt_nxt_s;
            pend_r <= pend_nxt_s;
            err_r  <= err_nxt_s;
            asm_r  <= asm_nxt_s;
            out_r  <= out_nxt_s;
        end
    end

endmodule

// File: tb/tb_stream_to_vector.sv
// Bench for stream_to_vector: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based frame model.
module tb_stream_to_vector;

    localparam int W = 12;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s2v_ready_in;
    logic          s2v_valid_in;
    logic          s2v_sof_in;
    logic [W-1:0]  s2v_data_in;
    logic [N-1:0]  s2v_ready_out;
    logic [N-1:0]  s2v_valid_out;
    logic [W-1:0]  s2v_data_out [0:N-1];
    logic          s2v_frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: samples collected for the frame in progress, the last completed vector,
    // which lanes of it are still undelivered, and the pending error pulse.
    logic [W-1:0] m_part [$];
    logic [W-1:0] m_out  [0:N-1] = '{default: 12'h000};
    logic [N-1:0] m_pend = 2'b00;
    logic         m_err  = 1'b0;
    logic         m_acc;

    stream_to_vector #(.DATA_WIDTH(W), .NUM_OUTPUTS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .s2v_ready_in  (s2v_ready_in),
        .s2v_valid_in  (s2v_valid_in),
        .s2v_sof_in    (s2v_sof_in),
        .s2v_data_in   (s2v_data_in),
        .s2v_ready_out (s2v_ready_out),
        .s2v_valid_out (s2v_valid_out),
        .s2v_data_out  (s2v_data_out),
        .s2v_frame_err (s2v_frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !((m_part.size() == N - 1) && (m_pend != 2'b00));
    endfunction

    // Compare DUT against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        chk("ready_in", 32'(s2v_ready_in), 32'(m_ready()));
        chk("valid_out", 32'(s2v_valid_out), 32'(m_pend));
        for (int i = 0; i < N; i++) chk("data_out", 32'(s2v_data_out[i]), 32'(m_out[i]));
        chk("frame_err", 32'(s2v_frame_err), 32'(m_err));
        if (rst) begin
            m_part.delete();
            m_pend = 2'b00;
            m_err  = 1'b0;
            for (int i = 0; i < N; i++) m_out[i] = 12'h000;
        end else begin
            m_acc  = s2v_valid_in && m_ready();
            m_err  = 1'b0;
            m_pend = m_pend & ~s2v_ready_out;
            if (m_acc) begin
                if (s2v_sof_in && m_part.size() != 0) begin
                    m_err = 1'b1;
                    m_part.delete();
                end
                m_part.push_back(s2v_data_in);
                if (m_part.size() == N) begin
                    for (int i = 0; i < N; i++) m_out[i] = m_part[i];
                    m_pend = 2'b11;
                    m_part.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the sample until accepted; returns just after the accepting edge with valid still high.
    task automatic send(input logic [W-1:0] d, input logic sof);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        s2v_valid_in = 1'b1;
        s2v_data_in  = d;
        s2v_sof_in   = sof;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = s2v_ready_in;
            step();
            t++;
        end
        chk("send_accepted", 32'(acc), 32'd1);
        s2v_sof_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s2v_valid_in = 1'b0; s2v_sof_in = 1'b0;
        s2v_data_in = 12'h000; s2v_ready_out = 2'b11;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(s2v_ready_in), 32'd1);
        chk("rst_valid", 32'(s2v_valid_out), 32'd0);
        chk("rst_d0", 32'(s2v_data_out[0]), 32'h000);
        chk("rst_d1", 32'(s2v_data_out[1]), 32'h000);
        chk("rst_err", 32'(s2v_frame_err), 32'd0);
        step();
        rst = 1'b0;

        // Single frame
        send(12'h200, 1'b0);
        send(12'h000, 1'b0);
        s2v_valid_in = 1'b0;
        @(negedge clk);
        chk("t2_valid", 32'(s2v_valid_out), 32'h3);
        chk("t2_d0", 32'(s2v_data_out[0]), 32'h200);
        chk("t2_d1", 32'(s2v_data_out[1]), 32'h000);
        step();
        @(negedge clk);
        chk("t2_drained", 32'(s2v_valid_out), 32'h0);
        step();

        // Backpressure and independent lane drain
        s2v_ready_out = 2'b00;
        send(12'h200, 1'b0);
        send(12'h200, 1'b0);
        send(12'h001, 1'b0);
        s2v_data_in = 12'h002; s2v_ready_out = 2'b01;
        @(negedge clk);
        chk("t3_ready_held", 32'(s2v_ready_in), 32'd0);
        chk("t3_valid_held", 32'(s2v_valid_out), 32'h3);
        step();
        s2v_ready_out = 2'b10;
        @(negedge clk);
        chk("t3_valid_lane1", 32'(s2v_valid_out), 32'h2);
        chk("t3_ready_still0", 32'(s2v_ready_in), 32'd0);
        step();
        @(negedge clk);
        chk("t3_ready_free", 32'(s2v_ready_in), 32'd1);
        step();
        s2v_valid_in = 1'b0; s2v_ready_out = 2'b11;
        @(negedge clk);
        chk("t3_valid2", 32'(s2v_valid_out), 32'h3);
        chk("t3_d0", 32'(s2v_data_out[0]), 32'h001);
        chk("t3_d1", 32'(s2v_data_out[1]), 32'h002);
        step();

        // Realign on sof
        send(12'h111, 1'b1);
        send(12'h222, 1'b1);
        s2v_data_in = 12'h333;
        @(negedge clk);
        chk("t4_err_pulse", 32'(s2v_frame_err), 32'd1);
        step();
        s2v_valid_in = 1'b0;
        @(negedge clk);
        chk("t4_err_clear", 32'(s2v_frame_err), 32'd0);
        chk("t4_valid", 32'(s2v_valid_out), 32'h3);
        chk("t4_d0", 32'(s2v_data_out[0]), 32'h222);
        chk("t4_d1", 32'(s2v_data_out[1]), 32'h333);
        step();

        // Reset mid-operation
        s2v_ready_out = 2'b00;
        send(12'h0aa, 1'b0);
        send(12'h0bb, 1'b0);
        send(12'h0cc, 1'b0);
        s2v_valid_in = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; s2v_ready_out = 2'b11;
        @(negedge clk);
        chk("t5_valid", 32'(s2v_valid_out), 32'h0);
        chk("t5_ready", 32'(s2v_ready_in), 32'd1);
        step();
        send(12'h005, 1'b0);
        send(12'h006, 1'b0);
        s2v_valid_in = 1'b0;
        @(negedge clk);
        chk("t5_vec_valid", 32'(s2v_valid_out), 32'h3);
        chk("t5_d0", 32'(s2v_data_out[0]), 32'h005);
        chk("t5_d1", 32'(s2v_data_out[1]), 32'h006);
        step();

        // Back-to-back streaming
        for (int i = 0; i < 8; i++) begin
            s2v_valid_in = 1'b1;
            s2v_data_in  = 12'(i + 1);
            @(negedge clk);
            chk("t6_ready", 32'(s2v_ready_in), 32'd1);
            chk("t6_valid", 32'(s2v_valid_out), (i > 0 && i % 2 == 0) ? 32'h3 : 32'h0);
            step();
        end
        s2v_valid_in = 1'b0;
        @(negedge clk);
        chk("t6_last_valid", 32'(s2v_valid_out), 32'h3);
        chk("t6_last_d0", 32'(s2v_data_out[0]), 32'h007);
        chk("t6_last_d1", 32'(s2v_data_out[1]), 32'h008);
        step();
        @(negedge clk);
        chk("t6_done", 32'(s2v_valid_out), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            rst           = ($urandom_range(0, 99) == 0);
            s2v_valid_in  = ($urandom_range(0, 3) != 0);
            s2v_sof_in    = ($urandom_range(0, 7) == 0);
            s2v_data_in   = 12'($urandom);
            s2v_ready_out = 2'($urandom);
        end
        step();
        rst = 1'b0; s2v_valid_in = 1'b0; s2v_sof_in = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_to_vector.md
Name: stream_to_vector

Overview:
Upstream feeder for the xor_net / cnn1d input layer. It accepts a scalar fixed-point sample stream on a single ready/valid handshake and packs NUM_OUTPUTS consecutive samples into one vector. The vector is presented on per-lane ready/valid outputs that match the network's per-input handshake. The block is double-buffered: an assembly buffer fills while the previous vector drains lane-by-lane.

Parameters:
DATA_WIDTH, cnn1d_pkg::DATA_WIDTH (12), sample width; signed Q2.9 fixed point, so 12'h200 = 1.0
NUM_OUTPUTS, 2, samples per vector; legal range >= 1

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
s2v_ready_in  output  1  block can accept a sample this cycle
s2v_valid_in  input  1  upstream sample valid
s2v_sof_in  input  1  start-of-frame marker, qualified by the input handshake
s2v_data_in  input  DATA_WIDTH  upstream sample
s2v_ready_out  input  NUM_OUTPUTS  per-lane downstream ready
s2v_valid_out  output  NUM_OUTPUTS  per-lane vector valid
s2v_data_out  output  DATA_WIDTH x [0:NUM_OUTPUTS-1]  unpacked vector; lane i = i-th sample of the frame
s2v_frame_err  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- State:
  - assembly buffer A[0:N-1] and lane counter cnt (0..N-1);
  - output buffer O[0:N-1] and pending mask P (N bits).
- Reset (rst=1 at an edge):
  - cnt=0, P=0, O all zero, frame_err=0, A all zero.
  - Outputs after reset: valid_out=0, data_out all 0, ready_in=1.
  - Reset mid-operation discards the partial frame and any undelivered lanes.
  - Reset has priority over every other event in the same cycle.
- Input acceptance:
  - accept = valid_in & ready_in.
  - ready_in = (cnt != N-1) | (P == 0).
  - ready_in is a function of registers only: no combinational path from ready_out to ready_in.
- On accept with sof_in=0, or sof_in=1 and cnt=0:
  - If cnt < N-1: A[cnt] <= data_in, cnt <= cnt+1.
  - If cnt = N-1 (frame complete): O <= {A[0..N-2], data_in}, P <= all ones, cnt <= 0.
- On accept with sof_in=1 and cnt != 0:
  - Partial frame is discarded; frame_err = 1 for the next cycle only.
  - data_in becomes lane 0: A[0] <= data_in, cnt <= 1.
  - If N = 1, sof never errors.
- sof_in is optional. Absence of sof_in is never an error; it only realigns the frame.
- Output lanes:
  - valid_out[i] = P[i], registered.
  - When valid_out[i] & ready_out[i], P[i] clears at the edge.
  - Lanes drain independently and in any order.
  - data_out holds O; O is unchanged until the next frame load.
- Simultaneous drain and load in one cycle: the load wins, so P <= all ones. This only occurs when the old P was already 0, which ready_in guarantees.
- Latency: the last sample of a frame accepted at edge k gives valid_out = all ones from edge k onward (visible in cycle k+1).
- Throughput:
  - N >= 2 with ready_out held all ones: 1 sample/cycle, ready_in never drops.
  - N = 1: 1 sample per 2 cycles worst case.
- valid_out[i] must not drop before its handshake, except on reset.
- Arithmetic: none. Data is passed bit-exact; no sign extension or saturation.

Test Plan:
1. Reset: rst=1 for 3 cycles -> ready_in=1, valid_out=2'b00, data_out={0,0}, frame_err=0.
2. Single frame, ready_out=2'b11: send 12'h200 then 12'h000 on consecutive cycles -> in the cycle after the 2nd accept, valid_out=2'b11, data_out[0]=12'h200, data_out[1]=12'h000; the next cycle valid_out=2'b00.
3. Backpressure, ready_out=2'b00, send 12'h200, 12'h200, 12'h001, 12'h002:
   - frame 1 is held and lane 0 of frame 2 (12'h001) is accepted;
   - ready_in=0 while cnt=1 with P=2'b11;
   - ready_out=2'b01 -> valid_out=2'b10, ready_in stays 0;
   - ready_out=2'b10 -> P=0, ready_in=1, 12'h002 is accepted;
   - the next vector is {12'h001, 12'h002}.
4. Realign: sof=1 with 12'h111, then sof=1 with 12'h222, then 12'h333 -> frame_err pulses exactly 1 cycle after the 2nd accept; the output vector is {12'h222, 12'h333}; 12'h111 never appears.
5. Reset mid-operation with P=2'b11 and cnt=1: assert rst for 1 cycle -> valid_out=2'b00 next cycle; the subsequent samples 12'h005, 12'h006 yield the vector {12'h005, 12'h006}.
6. Streaming: 8 back-to-back samples 12'h001..12'h008 with ready_out=2'b11 -> ready_in constantly 1; four vectors {1,2},{3,4},{5,6},{7,8} each valid for exactly 1 cycle, every second cycle.
